// File: rtl/tdm_demux4b4.sv
// rtl/tdm_demux4b4.sv - receiver for a 4-slot nibble TDM bus with slot-order checking
module tdm_demux4b4 #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       s,
    input  logic             valid,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             frame_valid,
    output logic             seq_err,
    output logic [ERRW-1:0]  err_cnt,
    output logic             busy
);

    // Expected slot; SLOT0 doubles as the idle state awaiting a frame start.
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    slot_t            exp_slot, exp_nxt;
    logic [WIDTH-1:0] stg0, stg1, stg2;
    logic [WIDTH-1:0] stg0_nxt, stg1_nxt, stg2_nxt;
    logic [WIDTH-1:0] o0_nxt, o1_nxt, o2_nxt, o3_nxt;
    logic             fv_nxt, se_nxt;
    logic [ERRW-1:0]  cnt_nxt;

    // State, staging and output registers; reset wins over a same-edge valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_slot    <= SLOT0;
            stg0        <= '0;
            stg1        <= '0;
            stg2        <= '0;
            o0          <= '0;
            o1          <= '0;
            o2          <= '0;
            o3          <= '0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            err_cnt     <= '0;
            busy        <= 1'b0;
        end else begin
            exp_slot    <= exp_nxt;
            stg0        <= stg0_nxt;
            stg1        <= stg1_nxt;
            stg2        <= stg2_nxt;
            o0          <= o0_nxt;
            o1          <= o1_nxt;
            o2          <= o2_nxt;
            o3          <= o3_nxt;
            frame_valid <= fv_nxt;
            seq_err     <= se_nxt;
            err_cnt     <= cnt_nxt;
            busy        <= (exp_nxt != SLOT0);
        end
    end

    // Next-state: capture in-order slots, publish on slot 3, resync or discard on order errors.
    always_comb begin
        exp_nxt  = exp_slot;
        stg0_nxt = stg0;
        stg1_nxt = stg1;
        stg2_nxt = stg2;
        o0_nxt   = o0;
        o1_nxt   = o1;
        o2_nxt   = o2;
        o3_nxt   = o3;
        fv_nxt   = 1'b0;
        se_nxt   = 1'b0;
        cnt_nxt  = err_cnt;
        if (valid) begin
            if (s == exp_slot) begin
                case (exp_slot)
                    SLOT0: begin
                        stg0_nxt = din;
                        exp_nxt  = SLOT1;
                    end
                    SLOT1: begin
                        stg1_nxt = din;
                        exp_nxt  = SLOT2;
                    end
                    SLOT2: begin
                        stg2_nxt = din;
                        exp_nxt  = SLOT3;
                    end
                    SLOT3: begin
                        o0_nxt  = stg0;
                        o1_nxt  = stg1;
                        o2_nxt  = stg2;
                        o3_nxt  = din;
                        fv_nxt  = 1'b1;
                        exp_nxt = SLOT0;
                    end
                    default: exp_nxt = SLOT0;
                endcase
            end else begin
                se_nxt = 1'b1;
                if (err_cnt != {ERRW{1'b1}}) begin
                    cnt_nxt = err_cnt + ERRW'(1);
                end
                // A stray slot 0 is taken as the start of a fresh frame.
                if (s == 2'd0) begin
                    stg0_nxt = din;
                    exp_nxt  = SLOT1;
                end else begin
                    exp_nxt = SLOT0;
                end
            end
        end
    end

endmodule

// File: doc/tdm_demux4b4.md
Name: tdm_demux4b4

Overview:
- Receiver end of the 4-channel, 4-bit time-multiplexed bus driven by the 4-to-1 nibble multiplexer (one nibble per slot, 2-bit slot select `s`).
- Captures one nibble per valid slot into staging registers and checks slot order 0,1,2,3.
- On a complete in-order frame, publishes all four nibbles at once to holding outputs and pulses `frame_valid`.
- Sits between the muxed bus and the downstream display/compare logic.

Parameters:
- WIDTH, 4, bit width of each channel nibble.
- ERRW, 8, width of the saturating sequence-error counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  muxed data for the current slot.
- s  input  2  slot index of `din` (0..3).
- valid  input  1  `din`/`s` are sampled on this clock edge.
- o0  output  WIDTH  channel 0 nibble of the last complete frame.
- o1  output  WIDTH  channel 1 nibble of the last complete frame.
- o2  output  WIDTH  channel 2 nibble of the last complete frame.
- o3  output  WIDTH  channel 3 nibble of the last complete frame.
- frame_valid  output  1  one-cycle pulse: o0..o3 were just updated.
- seq_err  output  1  one-cycle pulse: out-of-order slot received.
- err_cnt  output  ERRW  saturating count of sequence errors.
- busy  output  1  partial frame in progress (expected slot != 0).

Behaviour:
- Reset (rst=1 at an edge): o0..o3=0, staging=0, frame_valid=0, seq_err=0, err_cnt=0, expected slot exp=0, busy=0. rst overrides valid on the same edge.
- State is the 2-bit exp counter: 0=IDLE (awaiting slot 0), 1..3=COLLECT. busy = (exp != 0), registered.
- valid=0: all state holds; frame_valid=0 and seq_err=0 next cycle.
- valid=1 and s==exp, s<3: stg[s]<=din; exp<=exp+1.
- valid=1 and s==exp==3: on this edge, o0<=stg0, o1<=stg1, o2<=stg2, o3<=din; frame_valid<=1; exp<=0.
  - New outputs and the pulse are visible in the cycle after the slot-3 sample; latency is 1 clock.
- valid=1 and s!=exp: seq_err<=1; err_cnt<=err_cnt+1, saturating at 2^ERRW-1 (no wrap).
  - If s==0: resync as a new frame start, stg0<=din, exp<=1.
  - Otherwise: discard the partial frame, exp<=0.
  - o0..o3 are unchanged in both cases.
- A repeated slot 0 while exp=1 is an error and restarts the frame with the new nibble.
- o0..o3 change only on frame completion; they hold old values during collection and errors.
- frame_valid and seq_err are never both 1 in the same cycle.
- Back-to-back frames with valid held high every cycle give frame_valid once per 4 cycles.
- Reset mid-frame drops the partial frame; the first slot after reset must be 0.

Test Plan:
- Reset then frame 0101,1100,0011,1001 on slots 0..3 with valid high -> 1 cycle later: o0=0101, o1=1100, o2=0011, o3=1001, frame_valid=1 for exactly 1 cycle, err_cnt=0.
- Same frame with valid low for 2 cycles between each slot -> identical outputs; busy=1 from after slot 0 until after slot 3.
- Slots 0,1,3 -> seq_err pulse at the slot-3 sample, err_cnt=1, o0..o3 unchanged, exp=0. A following clean frame 1111,0000,1010,0101 is accepted.
- Slots 0,1 then 0 (din=0110),1,2,3 -> one seq_err; completed frame has o0=0110.
- Assert rst after slots 0,1,2, then send slot 3 alone -> all outputs 0, seq_err, err_cnt=1, no frame_valid.
- 300 consecutive slot-1 words from reset -> err_cnt saturates at 255; seq_err still pulses each time.
